// File: rtl/npu_mem_pkg.sv
// Shared definitions for the NPU output-memory datapath.
// Holds the geometry of the four-bank output memory (address width, word
// width, lane count), the address/word/row types derived from it, and the
// state encoding of the readout controller.
package npu_mem_pkg;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 16;
  localparam int LANES  = 4;
  localparam int LANE_W = $clog2(LANES);

  typedef logic [ADDR_W-1:0] mem_addr_t;
  // One extra bit so a full sweep of all 2^ADDR_W rows is representable.
  typedef logic [ADDR_W:0]   row_cnt_t;
  typedef logic [DATA_W-1:0] mem_word_t;
  typedef mem_word_t         mem_row_t [LANES];
  typedef logic [LANE_W-1:0] lane_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    FIN  = 2'd3
  } rd_state_t;

endpackage

// File: rtl/memory_out_reader.sv
// Read-side controller for the NPU output memory.
// On an accepted start it walks row_count rows from base_addr (wrapping at
// the top of the address space), reads the four bank words of each row and
// serialises them, lane 0 first, onto a 16-bit valid/ready stream.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start               one-cycle command strobe, honoured only in IDLE
//   base_addr           first row of the job (sampled on acceptance)
//   row_count           number of rows, 0..8192 (sampled on acceptance)
//   busy                high from accepted start until done
//   done                one-cycle completion pulse
//   mem_addr, mem_we    shared bank address; write enable tied low
//   mem_q               read data of the four banks (lane 0 = bank 0)
//   out_data, out_lane  stream word and the bank it came from
//   out_valid/out_ready stream handshake
//   out_last            marks lane 3 of the final row
module memory_out_reader
  import npu_mem_pkg::*;
#(
  parameter int READ_LATENCY = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      start,
  input  mem_addr_t base_addr,
  input  row_cnt_t  row_count,
  output logic      busy,
  output logic      done,
  output mem_addr_t mem_addr,
  output logic      mem_we,
  input  mem_row_t  mem_q,
  output mem_word_t out_data,
  output lane_t     out_lane,
  output logic      out_valid,
  input  logic      out_ready,
  output logic      out_last
);

  localparam logic [1:0] WAIT_RELOAD = 2'(READ_LATENCY);
  localparam lane_t      LAST_LANE   = lane_t'(LANES - 1);

  rd_state_t  state_q, state_d;
  mem_addr_t  mem_addr_q;
  row_cnt_t   rows_left_q;
  logic [1:0] wait_q;
  mem_row_t   row_buf_q;
  lane_t      lane_q;
  logic       out_valid_q;
  logic       busy_q;
  logic       done_q;
  logic       xfer_s;

  assign xfer_s = out_valid_q && out_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (row_count != '0) ? READ : FIN;
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        // Counter at zero means mem_q now reflects mem_addr.
        if (wait_q == 2'd0) begin
          state_d = SEND;
        end else begin
          state_d = READ;
        end
      end
      SEND: begin
        if (xfer_s && (lane_q == LAST_LANE)) begin
          state_d = (rows_left_q > row_cnt_t'(1)) ? READ : FIN;
        end else begin
          state_d = SEND;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath registers: address walk, row buffer, lane pointer, handshake flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_addr_q  <= '0;
      rows_left_q <= '0;
      wait_q      <= 2'd0;
      row_buf_q   <= '{default: '0};
      lane_q      <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
            // An empty job leaves the address untouched.
            if (row_count != '0) begin
              mem_addr_q  <= base_addr;
              rows_left_q <= row_count;
              wait_q      <= WAIT_RELOAD;
            end
          end
        end
        READ: begin
          if (wait_q == 2'd0) begin
            row_buf_q   <= mem_q;
            lane_q      <= '0;
            out_valid_q <= 1'b1;
          end else begin
            wait_q <= wait_q - 2'd1;
          end
        end
        SEND: begin
          if (xfer_s) begin
            if (lane_q != LAST_LANE) begin
              lane_q <= lane_q + lane_t'(1);
            end else begin
              out_valid_q <= 1'b0;
              if (rows_left_q > row_cnt_t'(1)) begin
                // Natural overflow gives the wrap from the top row to row 0.
                mem_addr_q  <= mem_addr_q + mem_addr_t'(1);
                rows_left_q <= rows_left_q - row_cnt_t'(1);
                wait_q      <= WAIT_RELOAD;
              end
            end
          end
        end
        FIN: begin
          done_q <= 1'b1;
          busy_q <= 1'b0;
        end
        default: begin
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Outputs: all derived from registers only, never from out_ready.
  always_comb begin
    out_data  = row_buf_q[lane_q];
    out_lane  = lane_q;
    out_valid = out_valid_q;
    out_last  = out_valid_q && (lane_q == LAST_LANE) && (rows_left_q == row_cnt_t'(1));
    busy      = busy_q;
    done      = done_q;
    mem_addr  = mem_addr_q;
    mem_we    = 1'b0;
  end

endmodule

// File: tb/tb_memory_out_reader.sv
module tb_memory_out_reader;
  import npu_mem_pkg::*;

  logic      clk = 1'b0;
  logic      rst_n, start, busy, done, mem_we, out_valid, out_ready, out_last;
  mem_addr_t base_addr, mem_addr;
  row_cnt_t  row_count;
  mem_row_t  mem_q;
  mem_word_t out_data;
  lane_t     out_lane;

  always #5 clk = ~clk;

  memory_out_reader #(.READ_LATENCY(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .row_count(row_count), .busy(busy), .done(done), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_q(mem_q), .out_data(out_data), .out_lane(out_lane),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
  );

  // Four single-port RAM banks, one-cycle registered read.
  mem_word_t ram [LANES][1 << ADDR_W];
  always_ff @(posedge clk) begin
    for (int b = 0; b < LANES; b++) mem_q[b] <= ram[b][mem_addr];
  end

  int checks = 0;
  int failures = 0;

  // Results gathered by collect()
  mem_word_t bd[$];
  lane_t     bl[$];
  logic      bls[$];
  int first_beat, done_cyc, done_cnt, busy_cnt, valid_cnt, stall_err, drop_err, timed_out;

  function automatic mem_word_t exp_word(int b, int row);
    logic [1:0]  bb;
    logic [12:0] rr;
    bb = 2'(b);
    rr = 13'(row % 8192);
    return {bb, 1'b0, rr};
  endfunction

  // Issue a start in the current cycle (cycle 0); returns in cycle 1.
  task automatic launch(input mem_addr_t b, input row_cnt_t n);
    start = 1'b1; base_addr = b; row_count = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Observe the stream from cycle 1 until two cycles after done (or max_cyc).
  // mode 0: out_ready always 1; mode 1: out_ready pattern 1,0,0,1.
  // junk_a/junk_b: cycles in which a spurious start is raised.
  task automatic collect(input int mode, input int junk_a, input int junk_b, input int max_cyc);
    logic pv, px;
    mem_word_t pd;
    lane_t pl;
    bd.delete(); bl.delete(); bls.delete();
    first_beat = -1; done_cyc = -1; done_cnt = 0; busy_cnt = 0; valid_cnt = 0;
    stall_err = 0; drop_err = 0; timed_out = 0;
    pv = 1'b0; px = 1'b0; pd = '0; pl = '0;
    for (int c = 1; c <= max_cyc; c++) begin
      start = (c == junk_a) || (c == junk_b);
      base_addr = 13'd300; row_count = 14'd5;
      out_ready = (mode == 0) ? 1'b1 : ((c % 4 == 0) || (c % 4 == 3));
      if (out_valid) valid_cnt++;
      if (pv && !px) begin
        if (!out_valid) drop_err++;
        else if (out_data !== pd || out_lane !== pl) stall_err++;
      end
      if (out_valid && out_ready) begin
        bd.push_back(out_data); bl.push_back(out_lane); bls.push_back(out_last);
        if (first_beat < 0) first_beat = c;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (busy) busy_cnt++;
      pv = out_valid; px = out_valid && out_ready; pd = out_data; pl = out_lane;
      if (done_cyc >= 0 && c >= done_cyc + 2) break;
      @(posedge clk); #1;
    end
    if (done_cyc < 0) timed_out = 1;
    start = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b1; base_addr = '0; row_count = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (mem_addr !== 13'd0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", mem_addr); end
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", mem_we); end
    checks++; if (out_data !== 16'h0000 || out_lane !== 2'd0) begin failures++; $display("FAIL reset_data got=%h/%0d exp=0/0", out_data, out_lane); end
    checks++; if (out_valid !== 1'b0 || out_last !== 1'b0) begin failures++; $display("FAIL reset_valid_last got=%b%b exp=00", out_valid, out_last); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_row();
    launch(13'd5, 14'd1);
    collect(0, -1, -1, 100);
    checks++; if (timed_out != 0) begin failures++; $display("FAIL single_timeout got=%0d exp=0", timed_out); end
    checks++; if (bd.size() != 4) begin failures++; $display("FAIL single_beats got=%0d exp=4", bd.size()); end
    for (int i = 0; i < 4 && i < bd.size(); i++) begin
      checks++; if (bd[i] !== exp_word(i, 5) || bl[i] !== lane_t'(i) || bls[i] !== (i == 3))
        begin failures++; $display("FAIL single_beat%0d got=%h/%0d/%b exp=%h/%0d/%b", i, bd[i], bl[i], bls[i], exp_word(i, 5), i, (i == 3)); end
    end
    checks++; if (first_beat != 3) begin failures++; $display("FAIL single_latency got=%0d exp=3", first_beat); end
    checks++; if (done_cyc != 8 || done_cnt != 1) begin failures++; $display("FAIL single_done got=cyc%0d/n%0d exp=cyc8/n1", done_cyc, done_cnt); end
    checks++; if (busy_cnt != 7) begin failures++; $display("FAIL single_busy got=%0d exp=7", busy_cnt); end
  endtask

  task automatic test_wrap();
    launch(13'd8190, 14'd3);
    collect(0, -1, -1, 200);
    checks++; if (bd.size() != 12) begin failures++; $display("FAIL wrap_beats got=%0d exp=12", bd.size()); end
    for (int i = 0; i < 12 && i < bd.size(); i++) begin
      checks++; if (bd[i] !== exp_word(i % 4, 8190 + i / 4) || bl[i] !== lane_t'(i % 4) || bls[i] !== (i == 11))
        begin failures++; $display("FAIL wrap_beat%0d got=%h/%0d/%b exp=%h/%0d/%b", i, bd[i], bl[i], bls[i], exp_word(i % 4, 8190 + i / 4), i % 4, (i == 11)); end
    end
    checks++; if (done_cyc != 20) begin failures++; $display("FAIL wrap_done got=%0d exp=20", done_cyc); end
  endtask

  task automatic test_stall();
    launch(13'd40, 14'd2);
    collect(1, -1, -1, 400);
    checks++; if (bd.size() != 8) begin failures++; $display("FAIL stall_beats got=%0d exp=8", bd.size()); end
    for (int i = 0; i < 8 && i < bd.size(); i++) begin
      checks++; if (bd[i] !== exp_word(i % 4, 40 + i / 4) || bl[i] !== lane_t'(i % 4))
        begin failures++; $display("FAIL stall_beat%0d got=%h/%0d exp=%h/%0d", i, bd[i], bl[i], exp_word(i % 4, 40 + i / 4), i % 4); end
    end
    checks++; if (stall_err != 0 || drop_err != 0) begin failures++; $display("FAIL stall_stable got=chg%0d/drop%0d exp=0/0", stall_err, drop_err); end
    checks++; if (valid_cnt <= 8) begin failures++; $display("FAIL stall_happened got=%0d exp=>8", valid_cnt); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL stall_done got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_zero_count();
    launch(13'd100, 14'd0);
    collect(0, -1, -1, 50);
    checks++; if (valid_cnt != 0 || bd.size() != 0) begin failures++; $display("FAIL zero_valid got=%0d exp=0", valid_cnt); end
    checks++; if (busy_cnt != 1) begin failures++; $display("FAIL zero_busy got=%0d exp=1", busy_cnt); end
    checks++; if (done_cyc != 2 || done_cnt != 1) begin failures++; $display("FAIL zero_done got=cyc%0d/n%0d exp=cyc2/n1", done_cyc, done_cnt); end
    checks++; if (mem_addr !== 13'd41) begin failures++; $display("FAIL zero_addr got=%0d exp=41", mem_addr); end
  endtask

  task automatic test_ignored_start();
    int extra;
    launch(13'd60, 14'd2);
    collect(0, 1, 4, 100);
    checks++; if (bd.size() != 8) begin failures++; $display("FAIL ign_beats got=%0d exp=8", bd.size()); end
    for (int i = 0; i < 8 && i < bd.size(); i++) begin
      checks++; if (bd[i] !== exp_word(i % 4, 60 + i / 4))
        begin failures++; $display("FAIL ign_beat%0d got=%h exp=%h", i, bd[i], exp_word(i % 4, 60 + i / 4)); end
    end
    checks++; if (done_cyc != 14 || done_cnt != 1) begin failures++; $display("FAIL ign_done got=cyc%0d/n%0d exp=cyc14/n1", done_cyc, done_cnt); end
    extra = 0;
    for (int c = 0; c < 6; c++) begin
      if (busy || out_valid) extra++;
      @(posedge clk); #1;
    end
    checks++; if (extra != 0) begin failures++; $display("FAIL ign_idle got=%0d exp=0", extra); end
  endtask

  task automatic test_reset_abort();
    int found, bad;
    launch(13'd20, 14'd2);
    found = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (out_valid && out_lane == 2'd1) begin found = 1; break; end
      @(posedge clk); #1;
    end
    checks++; if (found != 1) begin failures++; $display("FAIL abort_reach got=%0d exp=1", found); end
    @(posedge clk); #1;            // lane 1 transfers on this edge
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || mem_addr !== 13'd0 || out_data !== 16'h0000 ||
                  out_lane !== 2'd0 || out_valid !== 1'b0 || out_last !== 1'b0)
      begin failures++; $display("FAIL abort_outputs got=b%b d%b a%0d q%h l%0d v%b t%b exp=all0", busy, done, mem_addr, out_data, out_lane, out_valid, out_last); end
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      if (done || out_valid || busy) bad++;
      @(posedge clk); #1;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL abort_quiet got=%0d exp=0", bad); end
    launch(13'd7, 14'd1);
    collect(0, -1, -1, 100);
    checks++; if (bd.size() != 4) begin failures++; $display("FAIL abort_rerun_beats got=%0d exp=4", bd.size()); end
    for (int i = 0; i < 4 && i < bd.size(); i++) begin
      checks++; if (bd[i] !== exp_word(i, 7) || bl[i] !== lane_t'(i))
        begin failures++; $display("FAIL abort_rerun_beat%0d got=%h/%0d exp=%h/%0d", i, bd[i], bl[i], exp_word(i, 7), i); end
    end
    checks++; if (done_cyc != 8) begin failures++; $display("FAIL abort_rerun_done got=%0d exp=8", done_cyc); end
  endtask

  initial begin
    for (int b = 0; b < LANES; b++)
      for (int r = 0; r < (1 << ADDR_W); r++)
        ram[b][r] = exp_word(b, r);
    test_reset();
    test_single_row();
    test_wrap();
    test_stall();
    test_zero_count();
    test_ignored_start();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
